cordic_phase_gen: RTL and testbench

- Upstream stage of the CORDIC rotator: a numerically controlled phase accumulator.
- Produces one Q16.16 angle per cycle, folded into [-pi/2, +pi/2] to suit the rotator's convergence range.
- Carries a quadrant "flip" tag and valid bit through a delay line matched to rotator latency, so downstream logic can negate cosine in quadrants II/III.
- Burst/continuous run control via a small FSM.

---
 rtl/cordic_phase_gen_if.sv | 29 ++
 rtl/cordic_phase_gen.sv | 155 +++++++++++++++
 tb/tb_cordic_phase_gen.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/cordic_phase_gen_if.sv
// Control and sample bus between the phase generator and its neighbours.
// Inputs carry run control and phase settings; outputs carry folded angles and tags.
interface cordic_phase_gen_if #(
  parameter int unsigned CNT_W = 16
);
  localparam int unsigned DW = 32;

  logic             i_start;
  logic             i_stop;
  logic [CNT_W-1:0] i_count;
  logic [DW-1:0]    i_freq;
  logic [DW-1:0]    i_phase0;
  logic [DW-1:0]    o_theta;
  logic             o_flip;
  logic             o_valid;
  logic             o_flip_dly;
  logic             o_valid_dly;
  logic             o_busy;

  modport master (
    output i_start, i_stop, i_count, i_freq, i_phase0,
    input  o_theta, o_flip, o_valid, o_flip_dly, o_valid_dly, o_busy
  );

  modport slave (
    input  i_start, i_stop, i_count, i_freq, i_phase0,
    output o_theta, o_flip, o_valid, o_flip_dly, o_valid_dly, o_busy
  );
endinterface

// File: rtl/cordic_phase_gen.sv
// Phase accumulator feeding the CORDIC rotator: folds Q16.16 phase into [-pi/2, pi/2].
// Optional dither on theta via macro CORDIC_PHASE_DITHER_EN.
module cordic_phase_gen #(
  parameter int unsigned LATENCY = 30,
  parameter int unsigned CNT_W   = 16
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  cordic_phase_gen_if.slave bus
);
  localparam int unsigned DW = 32;
  localparam logic [DW-1:0] PI            = 32'h0003_243F;
  localparam logic [DW-1:0] TWO_PI        = 32'h0006_487E;
  localparam logic [DW-1:0] HALF_PI       = 32'h0001_921F;
  localparam logic [DW-1:0] THREE_HALF_PI = 32'h0004_B65E;

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_RUN} state_e;

  state_e           state_q, state_d;
  logic [DW-1:0]    phase_q, phase_d;
  logic [CNT_W-1:0] remaining_q, remaining_d;
  logic [DW-1:0]    theta_q, theta_d;
  logic             flip_q, flip_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic [LATENCY-1:0] vdly_q, fdly_q;

  logic [DW-1:0] step;
  logic [DW:0]   sum;
  logic [DW-1:0] phase_next;
  logic [DW-1:0] phase0_red;
  logic [DW-1:0] fold_theta;
  logic          fold_flip;
  logic [DW-1:0] theta_out;

  // Clamped step, wrapped accumulation and start-phase reduction
  always_comb begin
    step       = (bus.i_freq > PI) ? PI : bus.i_freq;
    sum        = {1'b0, phase_q} + {1'b0, step};
    phase_next = (sum >= {1'b0, TWO_PI}) ? DW'(sum - {1'b0, TWO_PI}) : DW'(sum);
    phase0_red = (bus.i_phase0 >= TWO_PI) ? (bus.i_phase0 - TWO_PI) : bus.i_phase0;
  end

  // Quadrant fold: quadrants II/III are mirrored through pi and tagged
  always_comb begin
    if (phase_q <= HALF_PI) begin
      fold_theta = phase_q;
      fold_flip  = 1'b0;
    end else if (phase_q < THREE_HALF_PI) begin
      fold_theta = PI - phase_q;
      fold_flip  = 1'b1;
    end else begin
      fold_theta = phase_q - TWO_PI;
      fold_flip  = 1'b0;
    end
  end

`ifdef CORDIC_PHASE_DITHER_EN
  localparam logic signed [DW:0] SAT_HI = 33'sh0_0001_921F;
  localparam logic signed [DW:0] SAT_LO = -SAT_HI;

  logic [15:0]          lfsr_q;
  logic signed [DW:0]   dith_sum;

  always_comb begin
    dith_sum = (DW+1)'(signed'(fold_theta)) + (DW+1)'(signed'(lfsr_q[1:0]));
    if (dith_sum > SAT_HI)      theta_out = HALF_PI;
    else if (dith_sum < SAT_LO) theta_out = DW'(SAT_LO);
    else                        theta_out = dith_sum[DW-1:0];
  end

  // Fibonacci LFSR, taps 16,14,13,11, stepped once per emitted sample
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)     lfsr_q <= 16'hACE1;
    else if (valid_d) lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  end
`else
  always_comb theta_out = fold_theta;
`endif

  // Next-state and registered-output logic
  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    remaining_d = remaining_q;
    theta_d     = theta_q;
    flip_d      = flip_q;
    valid_d     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.i_start) begin
          state_d     = ST_LOAD;
          phase_d     = phase0_red;
          remaining_d = bus.i_count;
        end
      end
      ST_LOAD: state_d = bus.i_stop ? ST_IDLE : ST_RUN;
      ST_RUN: begin
        if (bus.i_stop) begin
          state_d = ST_IDLE;
        end else begin
          theta_d = theta_out;
          flip_d  = fold_flip;
          valid_d = 1'b1;
          phase_d = phase_next;
          // Zero count means continuous; otherwise end after the last sample
          if (remaining_q != '0) begin
            remaining_d = remaining_q - CNT_W'(1);
            if (remaining_q == CNT_W'(1)) state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= ST_IDLE;
      phase_q     <= '0;
      remaining_q <= '0;
      theta_q     <= '0;
      flip_q      <= 1'b0;
      valid_q     <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      remaining_q <= remaining_d;
      theta_q     <= theta_d;
      flip_q      <= flip_d;
      valid_q     <= valid_d;
      busy_q      <= busy_d;
    end
  end

  // Tag delay line matched to rotator latency
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      vdly_q <= '0;
      fdly_q <= '0;
    end else begin
      vdly_q <= LATENCY'({vdly_q, valid_q});
      fdly_q <= LATENCY'({fdly_q, flip_q});
    end
  end

  assign bus.o_theta     = theta_q;
  assign bus.o_flip      = flip_q;
  assign bus.o_valid     = valid_q;
  assign bus.o_busy      = busy_q;
  assign bus.o_valid_dly = vdly_q[LATENCY-1];
  assign bus.o_flip_dly  = fdly_q[LATENCY-1];
endmodule

// File: tb/tb_cordic_phase_gen.sv
// Directed bench for cordic_phase_gen: table of bursts plus clamp, stop/start and reset sequences.
module tb_cordic_phase_gen;
  localparam int unsigned LAT = 30;
  localparam int unsigned CW  = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cordic_phase_gen_if #(.CNT_W(CW)) bus ();

  cordic_phase_gen #(.LATENCY(LAT), .CNT_W(CW)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct packed {
    logic [31:0]          phase0;
    logic [31:0]          freq;
    logic [15:0]          count;
    logic [0:7][31:0]     th;
    logic [0:7]           fl;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int k = 0; k < int'(LAT) + 5; k++) step();
  endtask

  // Burst from a table entry; checks samples, timing, busy and the delayed tags
  task automatic run_vec(input int v);
    logic hv[64];
    logic hf[64];
    int   idx;
    bus.i_phase0 = vecs[v].phase0;
    bus.i_freq   = vecs[v].freq;
    bus.i_count  = vecs[v].count;
    bus.i_start  = 1'b1;
    step();
    bus.i_start  = 1'b0;
    idx = 0;
    for (int c = 1; c <= int'(LAT) + 20; c++) begin
      if (c > 1) step();
      hv[c] = bus.o_valid;
      hf[c] = bus.o_flip;
      if (c == 1) chk($sformatf("v%0d busy_at_load", v), 32'(bus.o_busy), 32'd1);
      if (bus.o_valid) begin
        if (idx < 8) begin
          chk($sformatf("v%0d s%0d theta", v, idx), bus.o_theta, vecs[v].th[idx]);
          chk($sformatf("v%0d s%0d flip", v, idx), 32'(bus.o_flip), 32'(vecs[v].fl[idx]));
          chk($sformatf("v%0d s%0d cycle", v, idx), 32'(c), 32'(3 + idx));
        end
        idx++;
      end
      if (c > int'(LAT)) begin
        chk($sformatf("v%0d c%0d valid_dly", v, c), 32'(bus.o_valid_dly), 32'(hv[c-int'(LAT)]));
        if (hv[c-int'(LAT)])
          chk($sformatf("v%0d c%0d flip_dly", v, c), 32'(bus.o_flip_dly), 32'(hf[c-int'(LAT)]));
      end else begin
        chk($sformatf("v%0d c%0d valid_dly_early", v, c), 32'(bus.o_valid_dly), 32'd0);
      end
    end
    chk($sformatf("v%0d sample_count", v), 32'(idx), 32'(vecs[v].count));
    chk($sformatf("v%0d busy_end", v), 32'(bus.o_busy), 32'd0);
  endtask

  initial begin
    int n;

    vecs[0].phase0 = 32'h0;     vecs[0].freq = 32'h8000;  vecs[0].count = 16'd8;
    vecs[0].th = '{32'h0, 32'h8000, 32'h10000, 32'h18000, 32'h1243F, 32'hA43F, 32'h243F, 32'hFFFFA43F};
    vecs[0].fl = 8'b0000_1111;
    vecs[1].phase0 = 32'h64000; vecs[1].freq = 32'h1000;  vecs[1].count = 16'd2;
    vecs[1].th = '{32'hFFFFF782, 32'h782, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    vecs[1].fl = 8'b0000_0000;
    vecs[2].phase0 = 32'h6497E; vecs[2].freq = 32'h0;     vecs[2].count = 16'd2;
    vecs[2].th = '{32'h100, 32'h100, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    vecs[2].fl = 8'b0000_0000;
    vecs[3].phase0 = 32'h1921F; vecs[3].freq = 32'h1;     vecs[3].count = 16'd2;
    vecs[3].th = '{32'h1921F, 32'h1921F, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    vecs[3].fl = 8'b0100_0000;
    vecs[4].phase0 = 32'h4B65D; vecs[4].freq = 32'h1;     vecs[4].count = 16'd2;
    vecs[4].th = '{32'hFFFE6DE2, 32'hFFFE6DE0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    vecs[4].fl = 8'b1000_0000;
    vecs[5].phase0 = 32'h0;     vecs[5].freq = 32'h18000; vecs[5].count = 16'd5;
    vecs[5].th = '{32'h0, 32'h18000, 32'h243F, 32'hFFFEA43F, 32'hFFFFB782, 32'h0, 32'h0, 32'h0};
    vecs[5].fl = 8'b0011_0000;

    bus.i_start = 1'b0; bus.i_stop = 1'b0; bus.i_count = '0;
    bus.i_freq  = '0;   bus.i_phase0 = '0;

    #22;
    chk("reset theta", bus.o_theta, 32'h0);
    chk("reset valid", 32'(bus.o_valid), 32'd0);
    chk("reset busy", 32'(bus.o_busy), 32'd0);
    chk("reset valid_dly", 32'(bus.o_valid_dly), 32'd0);
    rst_n = 1'b1;
    step();

    for (int v = 0; v < 6; v++) run_vec(v);

    // Oversized step clamps to pi: phase alternates 0, pi
    bus.i_phase0 = 32'h0; bus.i_freq = 32'hFFFF_FFFF; bus.i_count = '0; bus.i_start = 1'b1;
    step();
    bus.i_start = 1'b0;
    step();
    for (int k = 0; k < 6; k++) begin
      step();
      chk($sformatf("clamp s%0d valid", k), 32'(bus.o_valid), 32'd1);
      chk($sformatf("clamp s%0d theta", k), bus.o_theta, 32'h0);
      chk($sformatf("clamp s%0d flip", k), 32'(bus.o_flip), 32'(k % 2));
    end
    bus.i_stop = 1'b1;
    step();
    bus.i_stop = 1'b0;
    chk("clamp stop valid", 32'(bus.o_valid), 32'd0);
    chk("clamp stop busy", 32'(bus.o_busy), 32'd0);
    chk("clamp stop theta_hold", bus.o_theta, 32'h0);
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("clamp idle%0d valid", k), 32'(bus.o_valid), 32'd0);
    end
    drain();

    // Start and stop together while idle: start wins
    bus.i_phase0 = 32'h1000; bus.i_freq = 32'h0; bus.i_count = 16'd3;
    bus.i_start = 1'b1; bus.i_stop = 1'b1;
    step();
    bus.i_start = 1'b0; bus.i_stop = 1'b0;
    chk("idle_both busy", 32'(bus.o_busy), 32'd1);
    step();
    chk("idle_both pre_valid", 32'(bus.o_valid), 32'd0);
    step();
    chk("idle_both valid", 32'(bus.o_valid), 32'd1);
    chk("idle_both theta", bus.o_theta, 32'h1000);
    step();
    step();
    step();
    chk("idle_both done valid", 32'(bus.o_valid), 32'd0);
    chk("idle_both done busy", 32'(bus.o_busy), 32'd0);

    // Start and stop together while running: stop wins, no restart
    bus.i_count = '0; bus.i_start = 1'b1;
    step();
    bus.i_start = 1'b0;
    step();
    step();
    chk("run_both running", 32'(bus.o_valid), 32'd1);
    bus.i_start = 1'b1; bus.i_stop = 1'b1;
    step();
    bus.i_start = 1'b0; bus.i_stop = 1'b0;
    chk("run_both valid", 32'(bus.o_valid), 32'd0);
    chk("run_both busy", 32'(bus.o_busy), 32'd0);
    for (int k = 0; k < 4; k++) begin
      step();
      chk($sformatf("run_both idle%0d valid", k), 32'(bus.o_valid), 32'd0);
      chk($sformatf("run_both idle%0d busy", k), 32'(bus.o_busy), 32'd0);
    end
    drain();

    // Reset in the middle of a long burst
    bus.i_phase0 = 32'h0; bus.i_freq = 32'h100; bus.i_count = 16'd100; bus.i_start = 1'b1;
    step();
    bus.i_start = 1'b0;
    n = 0;
    for (int k = 0; k < 60 && n < 40; k++) begin
      step();
      if (bus.o_valid) n++;
    end
    chk("midreset reached_40", 32'(n), 32'd40);
    chk("midreset pre_valid_dly", 32'(bus.o_valid_dly), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("midreset theta", bus.o_theta, 32'h0);
    chk("midreset flip", 32'(bus.o_flip), 32'd0);
    chk("midreset valid", 32'(bus.o_valid), 32'd0);
    chk("midreset busy", 32'(bus.o_busy), 32'd0);
    chk("midreset valid_dly", 32'(bus.o_valid_dly), 32'd0);
    chk("midreset flip_dly", 32'(bus.o_flip_dly), 32'd0);
    #2 rst_n = 1'b1;
    for (int k = 0; k < 50; k++) begin
      step();
      chk($sformatf("postreset c%0d valid", k), 32'(bus.o_valid), 32'd0);
      chk($sformatf("postreset c%0d valid_dly", k), 32'(bus.o_valid_dly), 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
